// File: rtl/lsq_pkg.sv
// Shared types and helpers for the scalar load/store queue.
// Struct fields are sized for the widest legal build and sliced at use.
package lsq_pkg;

    localparam int LSQ_MAX_W     = 64;
    localparam int LSQ_MAX_REG_W = 8;

    typedef enum logic [3:0] {
        LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, NONE
    } ls_op_t;

    typedef struct packed {
        logic [LSQ_MAX_W-1:0]     addr;
        logic [LSQ_MAX_W-1:0]     data;
        ls_op_t                   op;
        logic [LSQ_MAX_REG_W-1:0] rd;
        logic                     misal;
    } ls_req_t;

    // log2 of the access size in bytes
    function automatic logic [1:0] size_of(input ls_op_t op);
        case (op)
            LH, LHU, SH: return 2'd1;
            LW, LWU, SW: return 2'd2;
            LD, SD:      return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic is_load(input ls_op_t op);
        return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
    endfunction

endpackage

// File: rtl/lsq_fifo.sv
// In-order request queue; pointers carry one extra bit to tell full from empty.
module lsq_fifo
    import lsq_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ls_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    T            mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fu_scalar_lsq.sv
// Scalar load/store unit: in-order queue feeding one dcache request at a time.
// LS_MISALIGN_TRAP_EN: flag misaligned ops and complete them with ls_exc instead of force-aligning.
module fu_scalar_lsq
    import lsq_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    output logic              ready,
    input  logic [WORD_W-1:0] imm,
    input  logic [WORD_W-1:0] rs1,
    input  logic [WORD_W-1:0] rs2,
    input  ls_op_t            mem_type,
    input  logic [REG_W-1:0]  rd_in,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W/8-1:0] dmembyteen,
    input  logic [WORD_W-1:0] dmem_in,
    input  logic              dhit_in,
    output logic              wb_valid,
    output logic [WORD_W-1:0] dmemload,
    output logic [REG_W-1:0]  rd,
    output logic              dhit,
    output logic              ls_exc,
    output logic              busy
);
    localparam int NB  = WORD_W / 8;
    localparam int OFS = $clog2(NB);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;

    logic [1:0]        state;
    ls_req_t           req, head;
    logic              full, empty, push, pop, op_ok, op_wide;
    logic [1:0]        sz, h_sz;
    logic [WORD_W-1:0] addr_sum, low_mask, h_addr, shifted, fmask, ext;
    logic [OFS-1:0]    off;
    logic [NB-1:0]     bmask;
    logic              sbit, issue_mem, h_load;
    logic              wb_load, wb_exc;
    logic [REG_W-1:0]  wb_rd;
    logic [WORD_W-1:0] wb_data;
    logic              unused_head;

    // Enqueue side: effective address, alignment, request packing
    assign op_wide = mem_type inside {LD, SD, LWU};
    assign op_ok   = (mem_type != NONE) && (WORD_W == 64 || !op_wide);
    assign ready   = !full && !RST;
    assign push    = enable && ready && op_ok;

    always_comb begin
        sz       = size_of(mem_type);
        addr_sum = rs1 + imm;
        low_mask = WORD_W'((1 << sz) - 1);
        req      = '0;
        req.op   = mem_type;
        req.data = LSQ_MAX_W'(rs2);
        req.rd   = LSQ_MAX_REG_W'(rd_in);
`ifdef LS_MISALIGN_TRAP_EN
        req.addr  = LSQ_MAX_W'(addr_sum);
        req.misal = |(addr_sum & low_mask);
`else
        req.addr  = LSQ_MAX_W'(addr_sum & ~low_mask);
        req.misal = 1'b0;
`endif
    end

    lsq_fifo #(.DEPTH(DEPTH), .T(ls_req_t)) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Head side: lane steering for stores, extraction/extension for loads
    always_comb begin
        h_sz    = size_of(head.op);
        h_load  = is_load(head.op);
        h_addr  = head.addr[WORD_W-1:0];
        off     = h_addr[OFS-1:0];
        shifted = dmem_in >> {off, 3'b000};
        case (h_sz)
            2'd0:    begin fmask = WORD_W'(64'hFF);        bmask = NB'(1);  end
            2'd1:    begin fmask = WORD_W'(64'hFFFF);      bmask = NB'(3);  end
            2'd2:    begin fmask = WORD_W'(64'hFFFF_FFFF); bmask = NB'(15); end
            default: begin fmask = '1;                     bmask = NB'(255); end
        endcase
        // fmask ^ (fmask >> 1) isolates the field's top bit
        sbit = (head.op inside {LB, LH, LW}) && |(shifted & (fmask ^ (fmask >> 1)));
        ext  = (shifted & fmask) | (sbit ? ~fmask : '0);
    end

    assign issue_mem  = !RST && (state == S_ISSUE) && !head.misal;
    assign dmemREN    = issue_mem && h_load;
    assign dmemWEN    = issue_mem && !h_load;
    assign dmemaddr   = issue_mem ? {h_addr[WORD_W-1:OFS], {OFS{1'b0}}} : '0;
    assign dmembyteen = dmemWEN ? NB'(bmask << off) : '0;

    always_comb begin
        dmemstore = '0;
        if (dmemWEN) begin
            case (h_sz)
                2'd0:    dmemstore = {NB{head.data[7:0]}};
                2'd1:    dmemstore = {(NB/2){head.data[15:0]}};
                2'd2:    dmemstore = {(NB/4){head.data[31:0]}};
                default: dmemstore = head.data[WORD_W-1:0];
            endcase
        end
    end

    // Flagged heads bypass the dcache and retire without waiting for dhit_in
    assign pop = (state == S_ISSUE) && (head.misal || dhit_in);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            wb_load <= 1'b0;
            wb_exc  <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (!empty || push) state <= S_ISSUE;
                S_ISSUE: if (pop) begin
                    state   <= S_WB;
                    wb_load <= h_load;
                    wb_exc  <= head.misal;
                    wb_rd   <= head.rd[REG_W-1:0];
                    wb_data <= head.misal ? '0 : ext;
                end
                S_WB:    state <= (!empty || push) ? S_ISSUE : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dhit     = (state == S_WB);
    assign wb_valid = dhit && wb_load;
    assign dmemload = wb_valid ? wb_data : '0;
    assign rd       = wb_valid ? wb_rd : '0;
    assign busy     = !empty || (state != S_IDLE);
`ifdef LS_MISALIGN_TRAP_EN
    assign ls_exc = dhit && wb_exc;
`else
    assign ls_exc = 1'b0;
`endif

    assign unused_head = ^{head, wb_exc};

    a_op_width: assert property (@(posedge CLK) disable iff (RST)
        !(enable && op_wide && WORD_W != 64));

endmodule

// File: tb/tb_fu_scalar_lsq.sv
// Directed bench for fu_scalar_lsq (WORD_W=32, DEPTH=4): vector table plus multi-cycle sequences.
module tb_fu_scalar_lsq;
    import lsq_pkg::*;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        enable = 1'b0, dhit_in = 1'b0;
    logic [31:0] imm = '0, rs1 = '0, rs2 = '0, dmem_in = '0;
    ls_op_t      mem_type = NONE;
    logic [4:0]  rd_in = '0;
    logic        ready, dmemREN, dmemWEN, wb_valid, dhit, ls_exc, busy;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic [3:0]  dmembyteen;
    logic [4:0]  rd;

    int checks = 0, errors = 0;

    fu_scalar_lsq #(.WORD_W(32), .DEPTH(4), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .ready(ready), .imm(imm), .rs1(rs1),
        .rs2(rs2), .mem_type(mem_type), .rd_in(rd_in), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmembyteen(dmembyteen), .dmem_in(dmem_in), .dhit_in(dhit_in),
        .wb_valid(wb_valid), .dmemload(dmemload), .rd(rd), .dhit(dhit),
        .ls_exc(ls_exc), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        ls_op_t      op;
        logic [31:0] rs1, imm, rs2;
        logic [4:0]  rdi;
        logic [31:0] din;
        int          lat;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [3:0]  be;
        logic [31:0] load;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input ls_op_t op, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] d, input logic [4:0] r);
        enable = 1'b1; mem_type = op; rs1 = b; imm = o; rs2 = d; rd_in = r;
    endtask

    task automatic idle_in();
        enable = 1'b0; mem_type = NONE;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        drive(v.op, v.rs1, v.imm, v.rs2, v.rdi);
        @(negedge CLK);
        idle_in();
        chk({tag, "_ren"}, dmemREN, v.ren);
        chk({tag, "_wen"}, dmemWEN, v.wen);
        chk({tag, "_addr"}, dmemaddr, v.addr);
        chk({tag, "_store"}, dmemstore, v.store);
        chk({tag, "_be"}, dmembyteen, v.be);
        repeat (v.lat) @(negedge CLK);
        chk({tag, "_addr_hold"}, dmemaddr, v.addr);
        dmem_in = v.din;
        dhit_in = 1'b1;
        @(negedge CLK);
        dhit_in = 1'b0;
        chk({tag, "_dhit"}, dhit, 1'b1);
        chk({tag, "_wbv"}, wb_valid, v.ren);
        chk({tag, "_exc"}, ls_exc, 1'b0);
        if (v.ren) begin
            chk({tag, "_load"}, dmemload, v.load);
            chk({tag, "_rd"}, rd, v.rdi);
        end
        @(negedge CLK);
        chk({tag, "_dhit_off"}, dhit, 1'b0);
        chk({tag, "_wbv_off"}, wb_valid, 1'b0);
    endtask

    initial begin
        //            op   rs1           imm           rs2           rdi    din           lat ren  wen  addr          store         be       load
        vecs[0]  = '{LW,  32'h100,      32'h4,        32'h0,        5'd5,  32'hDEADBEEF, 3, 1'b1, 1'b0, 32'h104, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[1]  = '{LB,  32'h100,      32'h3,        32'h0,        5'd7,  32'h80112233, 1, 1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h100,      32'h3,        32'h0,        5'd8,  32'h80112233, 0, 1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h00000080};
        vecs[3]  = '{SH,  32'h100,      32'h2,        32'h0000ABCD, 5'd0,  32'h0,        2, 1'b0, 1'b1, 32'h100, 32'hABCDABCD, 4'b1100, 32'h0};
        vecs[4]  = '{LH,  32'h100,      32'h2,        32'h0,        5'd10, 32'h80017FFF, 0, 1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001};
        vecs[5]  = '{LHU, 32'h100,      32'h2,        32'h0,        5'd11, 32'h80017FFF, 0, 1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h00008001};
        vecs[6]  = '{SB,  32'h100,      32'h1,        32'h12345678, 5'd0,  32'h0,        1, 1'b0, 1'b1, 32'h100, 32'h78787878, 4'b0010, 32'h0};
        vecs[7]  = '{SW,  32'h200,      32'h0,        32'hCAFEF00D, 5'd0,  32'h0,        0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 4'b1111, 32'h0};
        vecs[8]  = '{LW,  32'hFFFFFFFC, 32'h8,        32'h0,        5'd12, 32'h11223344, 2, 1'b1, 1'b0, 32'h004, 32'h0,        4'b0000, 32'h11223344};
        vecs[9]  = '{LHU, 32'h108,      32'hFFFFFFFE, 32'h0,        5'd13, 32'hBEEF0000, 0, 1'b1, 1'b0, 32'h104, 32'h0,        4'b0000, 32'h0000BEEF};
        vecs[10] = '{LB,  32'h100,      32'h0,        32'h0,        5'd14, 32'h0000007F, 0, 1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h0000007F};

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_ready", ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ren", dmemREN, 1'b0);
        chk("rst_dhit", dhit, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", ready, 1'b1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Enqueue on the same cycle as the head's dhit_in
        @(negedge CLK);
        drive(LW, 32'h40, 32'h0, 32'h0, 5'd3);
        @(negedge CLK);
        chk("sim_a_addr", dmemaddr, 32'h40);
        drive(LW, 32'h44, 32'h0, 32'h0, 5'd4);
        dmem_in = 32'h55; dhit_in = 1'b1;
        @(negedge CLK);
        idle_in(); dhit_in = 1'b0;
        chk("sim_a_rd", rd, 5'd3);
        chk("sim_a_load", dmemload, 32'h55);
        chk("sim_busy", busy, 1'b1);
        @(negedge CLK);
        chk("sim_b_ren", dmemREN, 1'b1);
        chk("sim_b_addr", dmemaddr, 32'h44);
        dmem_in = 32'h66; dhit_in = 1'b1;
        @(negedge CLK);
        dhit_in = 1'b0;
        chk("sim_b_rd", rd, 5'd4);
        chk("sim_b_load", dmemload, 32'h66);
        @(negedge CLK);
        chk("sim_idle_busy", busy, 1'b0);

        // Fill beyond DEPTH with the dcache stalled, then drain in order
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 4) chk("full_ready", ready, 1'b0);
            drive(LW, 32'h10 + 32'(4 * i), 32'h0, 32'h0, 5'(i + 1));
        end
        @(negedge CLK);
        idle_in();
        chk("full_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_ren", i), dmemREN, 1'b1);
            chk($sformatf("drain%0d_addr", i), dmemaddr, 32'h10 + 32'(4 * i));
            dmem_in = 32'h1000 + 32'(i); dhit_in = 1'b1;
            @(negedge CLK);
            dhit_in = 1'b0;
            chk($sformatf("drain%0d_wbv", i), wb_valid, 1'b1);
            chk($sformatf("drain%0d_rd", i), rd, 5'(i + 1));
            chk($sformatf("drain%0d_load", i), dmemload, 32'h1000 + 32'(i));
            if (i == 0) chk("drain_ready_back", ready, 1'b1);
            @(negedge CLK);
        end
        chk("drain_ren_off", dmemREN, 1'b0);
        chk("drain_busy", busy, 1'b0);

        // Reset mid-flight: REN must drop without a clock edge
        drive(LW, 32'h80, 32'h0, 32'h0, 5'd2);
        @(negedge CLK);
        idle_in();
        chk("midrst_ren_before", dmemREN, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("midrst_ren_async", dmemREN, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        dhit_in = 1'b1;
        @(negedge CLK);
        dhit_in = 1'b0;
        chk("late_dhit", dhit, 1'b0);
        chk("late_wbv", wb_valid, 1'b0);
        chk("late_ready", ready, 1'b1);

        // Misaligned word load
        @(negedge CLK);
        drive(LW, 32'h100, 32'h1, 32'h0, 5'd6);
        @(negedge CLK);
        idle_in();
`ifdef LS_MISALIGN_TRAP_EN
        chk("mis_ren", dmemREN, 1'b0);
        chk("mis_wen", dmemWEN, 1'b0);
        @(negedge CLK);
        chk("mis_exc", ls_exc, 1'b1);
        chk("mis_dhit", dhit, 1'b1);
        chk("mis_wbv", wb_valid, 1'b1);
        chk("mis_load", dmemload, 32'h0);
        chk("mis_rd", rd, 5'd6);
        @(negedge CLK);
        chk("mis_exc_off", ls_exc, 1'b0);
`else
        chk("mis_ren", dmemREN, 1'b1);
        chk("mis_addr", dmemaddr, 32'h100);
        dmem_in = 32'h12345678; dhit_in = 1'b1;
        @(negedge CLK);
        dhit_in = 1'b0;
        chk("mis_load", dmemload, 32'h12345678);
        chk("mis_exc", ls_exc, 1'b0);
        @(negedge CLK);
`endif
        chk("end_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
